// File: rtl/uk101_pkg.sv
// Shared UK101 constants and the ASCII text loader state type.
package uk101_pkg;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] TXT_IOCTL_INDEX = 8'h00;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} txt_ld_state_t;
endpackage

// File: rtl/txt_fifo.sv
// Single-clock byte FIFO with fill count and full/empty flags; read data is
// registered on pop so the consumer picks it up one cycle later.
module txt_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [7:0]       i_din,
    input  logic             i_pop,
    output logic [7:0]       o_dout,
    output logic [FIFO_AW:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [7:0]         r_dout;
    logic               w_push, w_pop;

    assign o_full  = (r_count == (FIFO_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    // Pointers are exactly FIFO_AW bits wide, so they wrap modulo depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
                r_dout <= r_mem[r_rptr];
            end
            r_count <= r_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
        end
    end

    assign o_dout  = r_dout;
    assign o_count = r_count;
endmodule

// File: rtl/txt_loader.sv
// Paces "Load Ascii" download bytes into the UK101 ACIA receive path.
// Optional CR/LF folding at the FIFO input: define TXT_LOADER_EOL_CONV_EN.
module txt_loader
    import uk101_pkg::*;
#(
    parameter int FIFO_AW  = 4,
    parameter int CHAR_GAP = 48000,
    parameter int LINE_GAP = 960000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enable,
    input  logic       ioctl_download,
    input  logic [7:0] ioctl_index,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_data,
    output logic       ioctl_wait,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overflow
);
    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam int               CW       = $clog2(LINE_GAP + 1);
    localparam logic [FIFO_AW:0] WAIT_LVL = (FIFO_AW+1)'(DEPTH - 2);

    txt_ld_state_t    r_state;
    logic [CW-1:0]    r_gap;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid, r_wait, r_overflow;
    logic             w_acc, w_drop, w_push, w_pop, w_full, w_empty;
    logic [7:0]       w_byte, w_fifo_dout;
    logic [FIFO_AW:0] w_count, w_cnt_nxt;

    assign w_acc = ioctl_download & ioctl_wr & enable & (ioctl_index == TXT_IOCTL_INDEX);

`ifdef TXT_LOADER_EOL_CONV_EN
    logic r_dl_d, r_last_cr, w_last_cr;

    // A write can only be accepted with download high, so masking by the
    // delayed download bit clears the flag on the rising edge itself.
    assign w_last_cr = r_last_cr & r_dl_d;

    always_comb begin
        w_byte = ioctl_data;
        w_drop = 1'b0;
        if (ioctl_data == ASCII_LF) begin
            if (w_last_cr) w_drop = 1'b1;
            else           w_byte = ASCII_CR;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_d    <= 1'b0;
            r_last_cr <= 1'b0;
        end else begin
            r_dl_d <= ioctl_download;
            if (ioctl_download & ~r_dl_d) r_last_cr <= 1'b0;
            if (w_acc)                    r_last_cr <= (ioctl_data == ASCII_CR);
        end
    end
`else
    assign w_byte = ioctl_data;
    assign w_drop = 1'b0;
`endif

    assign w_push    = w_acc & ~w_drop & ~w_full;
    assign w_pop     = (r_state == IDLE) & ~w_empty;
    assign w_cnt_nxt = w_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

    txt_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk     (clk_sys),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_byte),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gap      <= '0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_wait     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // Stall on the next count so the source sees wait one cycle after
            // the write that reached depth-2, leaving one slot of slack.
            r_wait <= (w_cnt_nxt >= WAIT_LVL);
            if (w_acc & ~w_drop & w_full) r_overflow <= 1'b1;

            case (r_state)
                IDLE: if (!w_empty) r_state <= LOAD;
                LOAD: begin
                    r_rx_data  <= w_fifo_dout;
                    r_rx_valid <= 1'b1;
                    r_state    <= SEND;
                end
                SEND: if (rx_ready) begin
                    r_rx_valid <= 1'b0;
                    r_gap      <= (r_rx_data == ASCII_CR) ? CW'(LINE_GAP) : CW'(CHAR_GAP);
                    r_state    <= GAP;
                end
                GAP: begin
                    if (r_gap == '0) r_state <= IDLE;
                    else             r_gap   <= r_gap - CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ioctl_wait = r_wait;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign overflow   = r_overflow;
    assign busy       = ~w_empty | (r_state != IDLE);
endmodule
